// File: rtl/safe_softmax_exp_pipe.sv
// Multi-lane, 3-stage pipelined exp(x) for safe-softmax (x <= 0).
// exp(x) = 2^-(u+v): x*log2(e) range reduction, 2^-v table lookup, right shift by u.
// Valid/ready flow control, per-lane masking, positive-input flag and row-sum accumulator.
module safe_softmax_exp_pipe #(
    parameter int unsigned D_W    = 16,
    parameter int unsigned FRAC_W = 13,
    parameter int unsigned LANES  = 4,
    parameter int unsigned LUT_AW = 8,
    parameter int unsigned SUM_W  = 24
) (
    input  logic                   I_CLK,
    input  logic                   I_RST,
    input  logic                   I_VALID,
    output logic                   O_READY,
    input  logic [LANES*D_W-1:0]   I_X,
    input  logic [LANES-1:0]       I_MASK,
    input  logic                   I_LAST,
    output logic                   O_VALID,
    input  logic                   I_READY,
    output logic [LANES*D_W-1:0]   O_EXP,
    output logic                   O_LAST,
    output logic [SUM_W-1:0]       O_SUM,
    output logic                   O_SUM_VLD,
    output logic                   O_POS_ERR
);

    localparam int unsigned NW   = D_W + 2;       // width of -t, never overflows
    localparam int unsigned PW   = 2 * D_W;       // product width
    localparam int unsigned UW   = NW - FRAC_W;   // integer part of n
    localparam int unsigned LutN = 1 << LUT_AW;
    localparam logic [127:0] Ln2Q64 = 128'hB17217F7D1CF79AB;  // ln(2) * 2^64

    // round(2^FRAC_W / ln2) = round(log2(e) * 2^FRAC_W)
    function automatic logic [PW-1:0] calc_k();
        logic [127:0] q;
        q = ((128'd1 << (FRAC_W + 64)) + (Ln2Q64 >> 1)) / Ln2Q64;
        return q[PW-1:0];
    endfunction

    // Table of min(round(2^FRAC_W * 2^-(i/2^LUT_AW)), 2^FRAC_W-1), built with a Q64 series for exp(-z)
    function automatic logic [LutN*FRAC_W-1:0] build_lut();
        logic [LutN*FRAC_W-1:0] tbl;
        logic [127:0] z, term, acc, l;
        tbl = '0;
        for (int i = 0; i < int'(LutN); i++) begin
            z    = (128'(i) * Ln2Q64) >> LUT_AW;
            term = 128'd1 << 64;
            acc  = term;
            for (int k = 1; k < 24; k++) begin
                term = ((term * z) >> 64) / 128'(k);
                if ((k % 2) == 1) acc = acc - term;
                else              acc = acc + term;
            end
            l = ((acc << FRAC_W) + (128'd1 << 63)) >> 64;
            if (l > ((128'd1 << FRAC_W) - 1)) l = (128'd1 << FRAC_W) - 1;
            tbl[i*FRAC_W +: FRAC_W] = l[FRAC_W-1:0];
        end
        return tbl;
    endfunction

    localparam logic signed [PW-1:0]    KMul    = calc_k();
    localparam logic signed [PW-1:0]    RndHalf = PW'(1) << (FRAC_W - 1);
    localparam logic [LutN*FRAC_W-1:0]  LutFlat = build_lut();
    localparam logic [FRAC_W-1:0]       YMax    = '1;

    logic advance, accept, handshake;

    logic                          s1_valid_q, s1_last_q;
    logic [LANES-1:0]              s1_mask_q, s1_force_q;
    logic [LANES-1:0][NW-1:0]      s1_t_q, s1_t_d;
    logic [LANES-1:0]              force_d;
    logic                          pos_hit;

    logic                          s2_valid_q, s2_last_q;
    logic [LANES-1:0]              s2_mask_q, s2_force_q;
    logic [LANES-1:0][UW-1:0]      s2_u_q, s2_u_d;
    logic [LANES-1:0][FRAC_W-1:0]  s2_l_q, s2_l_d;

    logic                          o_valid_q, o_last_q;
    logic [LANES*D_W-1:0]          o_exp_q, o_exp_d;

    logic [SUM_W-1:0]              acc_q, sum_q;
    logic                          sum_vld_q, pos_err_q;
    logic [SUM_W:0]                beat_sum, acc_sum;
    logic [SUM_W-1:0]              acc_sat;

    assign advance   = !o_valid_q || I_READY;
    assign accept    = I_VALID && advance;
    assign handshake = o_valid_q && I_READY;

    // S1: x*K with round-half-up shift; flag x >= 0 lanes and unmasked positive inputs
    always_comb begin
        logic signed [D_W-1:0] x_s;
        logic signed [PW-1:0]  p, sh;
        s1_t_d  = '0;
        force_d = '0;
        pos_hit = 1'b0;
        for (int k = 0; k < int'(LANES); k++) begin
            x_s        = I_X[k*D_W +: D_W];
            p          = PW'(x_s) * KMul;
            sh         = (p + RndHalf) >>> FRAC_W;
            s1_t_d[k]  = sh[NW-1:0];
            force_d[k] = !x_s[D_W-1];
            if (!I_MASK[k] && (x_s > 0)) pos_hit = 1'b1;
        end
    end

    // S2: n = -t, split into integer shift u and table index from the top of v
    always_comb begin
        logic [NW-1:0]     n;
        logic [LUT_AW-1:0] idx;
        s2_u_d = '0;
        s2_l_d = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            n         = -s1_t_q[k];
            s2_u_d[k] = n[NW-1:FRAC_W];
            idx       = n[FRAC_W-1 -: LUT_AW];
            s2_l_d[k] = LutFlat[int'(idx)*FRAC_W +: FRAC_W];
        end
    end

    // S3: shift by u, then apply mask / non-negative overrides
    always_comb begin
        logic [FRAC_W-1:0] y;
        o_exp_d = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (s2_mask_q[k])                 y = '0;
            else if (s2_force_q[k])           y = YMax;
            else if (int'(s2_u_q[k]) > FRAC_W) y = '0;
            else                              y = s2_l_q[k] >> s2_u_q[k];
            o_exp_d[k*D_W +: D_W] = D_W'(y);
        end
    end

    // Saturating row accumulation of the beat leaving the output register
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            beat_sum = beat_sum + (SUM_W+1)'(o_exp_q[k*D_W +: D_W]);
        end
        acc_sum = {1'b0, acc_q} + beat_sum;
        acc_sat = acc_sum[SUM_W] ? '1 : acc_sum[SUM_W-1:0];
    end

    // Pipeline registers; every stage holds together when the output is stalled
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            s1_valid_q <= 1'b0; s1_last_q <= 1'b0; s1_mask_q <= '0; s1_force_q <= '0; s1_t_q <= '0;
            s2_valid_q <= 1'b0; s2_last_q <= 1'b0; s2_mask_q <= '0; s2_force_q <= '0;
            s2_u_q     <= '0;   s2_l_q    <= '0;
            o_valid_q  <= 1'b0; o_last_q  <= 1'b0; o_exp_q   <= '0;
        end else if (advance) begin
            s1_valid_q <= I_VALID;    s1_last_q <= I_LAST;    s1_mask_q <= I_MASK;
            s1_force_q <= force_d;    s1_t_q    <= s1_t_d;
            s2_valid_q <= s1_valid_q; s2_last_q <= s1_last_q; s2_mask_q <= s1_mask_q;
            s2_force_q <= s1_force_q; s2_u_q    <= s2_u_d;    s2_l_q    <= s2_l_d;
            o_valid_q  <= s2_valid_q; o_last_q  <= s2_last_q; o_exp_q   <= o_exp_d;
        end
    end

    // Row sum, one-cycle sum pulse and sticky positive-input flag
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            acc_q     <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            pos_err_q <= 1'b0;
        end else begin
            sum_vld_q <= 1'b0;
            if (handshake) begin
                if (o_last_q) begin
                    acc_q     <= '0;
                    sum_q     <= acc_sat;
                    sum_vld_q <= 1'b1;
                end else begin
                    acc_q <= acc_sat;
                end
            end
            if (accept && pos_hit) pos_err_q <= 1'b1;
        end
    end

    assign O_READY   = advance;
    assign O_VALID   = o_valid_q;
    assign O_EXP     = o_exp_q;
    assign O_LAST    = o_last_q;
    assign O_SUM     = sum_q;
    assign O_SUM_VLD = sum_vld_q;
    assign O_POS_ERR = pos_err_q;

endmodule
